uart_rx_core: RTL

UART serial receiver for the far end of the UART TXD line. It recovers 5–8 bit frames from a serial input using a 16x oversampling enable. Each frame is delivered as a byte with per-frame parity, framing and break flags, through a single-entry valid/ready holding register. The block is the checking counterpart of the UART transmitter and is driven by the same 16x baud-generator enable.

---
 rtl/uart_rx_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: 16x-oversampled 5-8 bit frames with optional parity, framing/break
// detection and a single-entry valid/ready holding register.
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter int OVS         = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       baud_tick,
    input  logic       RXD,
    input  logic       rx_enable,
    input  logic [1:0] cfg_wls,
    input  logic       cfg_pen,
    input  logic       cfg_eps,
    output logic [7:0] rx_data,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int TW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    state_t                 state, state_d;
    logic [TW-1:0]          tick_cnt, tick_d;
    logic [2:0]             bit_cnt, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;    // running XOR of data bits
    logic                   zero_q, zero_d;  // every sampled bit so far was 0
    logic                   pe_q, pe_d;
    logic [1:0]             wls_q, wls_d;
    logic                   pen_q, pen_d;
    logic                   eps_q, eps_d;
    logic                   frame_done, fe_new, bi_new;

    assign rxd_s     = sync_q[SYNC_STAGES-1];
    assign rx_busy   = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_d    = state;
        tick_d     = tick_cnt;
        bit_d      = bit_cnt;
        shift_d    = shift_q;
        par_d      = par_q;
        zero_d     = zero_q;
        pe_d       = pe_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        frame_done = 1'b0;
        fe_new     = 1'b0;
        bi_new     = 1'b0;
        if (!rx_enable) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else if (baud_tick) begin
            case (state)
                IDLE: if (!rxd_s) begin
                    state_d = START;
                    tick_d  = '0;
                    shift_d = '0;
                    par_d   = 1'b0;
                    zero_d  = 1'b1;
                    pe_d    = 1'b0;
                    wls_d   = cfg_wls;
                    pen_d   = cfg_pen;
                    eps_d   = cfg_eps;
                end
                START: if (tick_cnt == TICK_MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
                DATA: if (tick_cnt == TICK_LAST) begin
                    tick_d           = '0;
                    shift_d[bit_cnt] = rxd_s;
                    par_d            = par_q ^ rxd_s;
                    zero_d           = zero_q & ~rxd_s;
                    // last data bit index is word length - 1 = 4 + wls
                    if (bit_cnt == {1'b1, wls_q}) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
                PARITY: if (tick_cnt == TICK_LAST) begin
                    tick_d  = '0;
                    // error when total XOR differs from 0 (even) / 1 (odd)
                    pe_d    = ((par_q ^ rxd_s) == eps_q);
                    zero_d  = zero_q & ~rxd_s;
                    state_d = STOP;
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
                STOP: if (tick_cnt == TICK_LAST) begin
                    tick_d     = '0;
                    frame_done = 1'b1;
                    fe_new     = ~rxd_s;
                    bi_new     = zero_q & ~rxd_s;
                    state_d    = rxd_s ? IDLE : BRK_WAIT;
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
                BRK_WAIT: if (rxd_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q     <= '1;
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            zero_q     <= 1'b0;
            pe_q       <= 1'b0;
            wls_q      <= '0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            rx_data    <= '0;
            rx_pe      <= 1'b0;
            rx_fe      <= 1'b0;
            rx_bi      <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], RXD};
            state    <= state_d;
            tick_cnt <= tick_d;
            bit_cnt  <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            zero_q   <= zero_d;
            pe_q     <= pe_d;
            wls_q    <= wls_d;
            pen_q    <= pen_d;
            eps_q    <= eps_d;
            // handshake: valid/ready transfer on any cycle with both high;
            // a completing frame may refill the register in the same cycle
            rx_overrun <= frame_done & rx_valid & ~rx_ready;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_d;
                rx_pe    <= pe_q;
                rx_fe    <= fe_new;
                rx_bi    <= bi_new;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
